// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the accumulator CPU control path.
// SEQ_HALT_EN adds the HALT state so opcode 111 stops the machine.
package cpu_defs_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_LOAD  = 3'b000,
    OP_STORE = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_BNE   = 3'b100,
    OP_BEQ   = 3'b101,
    OP_JMP   = 3'b110,
    OP_HALT  = 3'b111
  } opcode_t;

  typedef enum logic [2:0] {
    BOOT,
    FETCH_A,
    FETCH_I,
    DECODE,
    EXEC
`ifdef SEQ_HALT_EN
    , HALT
`endif
  } state_t;

  typedef struct packed {
    logic pc_bus;
    logic ir_bus;
    logic acc_bus;
    logic load_pc;
    logic inc_pc;
    logic load_ir;
    logic load_mar;
    logic load_acc;
    logic alu_acc;
    logic alu_add;
    logic alu_sub;
    logic cs;
    logic r_nw;
  } ctrl_t;

endpackage

// File: rtl/sequencer.sv
// Fetch/decode/execute control unit for the accumulator CPU.
// SEQ_HALT_EN makes opcode 111 halt until reset; otherwise it is a NOP.
module sequencer #(
  parameter int OP_W   = cpu_defs_pkg::OP_W,
  parameter int WORD_W = 8
) (
  input  logic            clock,
  input  logic            n_reset,
  input  logic [OP_W-1:0] op,
  input  logic            z_flag,
  output logic            PC_bus,
  output logic            IR_bus,
  output logic            ACC_bus,
  output logic            load_PC,
  output logic            INC_PC,
  output logic            load_IR,
  output logic            load_MAR,
  output logic            load_ACC,
  output logic            ALU_ACC,
  output logic            ALU_add,
  output logic            ALU_sub,
  output logic            CS,
  output logic            R_NW,
  output logic            halted
);

  import cpu_defs_pkg::*;

  state_t state_q, state_d;
  ctrl_t  ctrl;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) state_q <= BOOT;
    else          state_q <= state_d;
  end

  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    unique case (state_q)
      BOOT: state_d = FETCH_A;
      FETCH_A: begin
        ctrl.pc_bus   = 1'b1;
        ctrl.load_mar = 1'b1;
        ctrl.load_pc  = 1'b1;
        ctrl.inc_pc   = 1'b1;
        state_d       = FETCH_I;
      end
      FETCH_I: begin
        ctrl.cs      = 1'b1;
        ctrl.r_nw    = 1'b1;
        ctrl.load_ir = 1'b1;
        state_d      = DECODE;
      end
      DECODE: begin
        ctrl.ir_bus = 1'b1;
        state_d     = FETCH_A;
        case (op)
          OP_LOAD, OP_STORE, OP_ADD, OP_SUB: begin
            ctrl.load_mar = 1'b1;
            state_d       = EXEC;
          end
          OP_JMP: ctrl.load_pc = 1'b1;
          OP_BNE: ctrl.load_pc = !z_flag;
          OP_BEQ: ctrl.load_pc = z_flag;
`ifdef SEQ_HALT_EN
          OP_HALT: state_d = HALT;
`endif
          default: ;
        endcase
      end
      EXEC: begin
        state_d = FETCH_A;
        case (op)
          OP_LOAD: begin
            ctrl.cs       = 1'b1;
            ctrl.r_nw     = 1'b1;
            ctrl.load_acc = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl.cs       = 1'b1;
            ctrl.r_nw     = 1'b1;
            ctrl.load_acc = 1'b1;
            ctrl.alu_acc  = 1'b1;
            ctrl.alu_add  = (op == OP_ADD);
            ctrl.alu_sub  = (op == OP_SUB);
          end
          OP_STORE: begin
            ctrl.acc_bus = 1'b1;
            ctrl.cs      = 1'b1;
          end
          default: ;
        endcase
      end
`ifdef SEQ_HALT_EN
      HALT: state_d = HALT;
`endif
      default: state_d = BOOT;
    endcase
  end

  assign PC_bus   = ctrl.pc_bus;
  assign IR_bus   = ctrl.ir_bus;
  assign ACC_bus  = ctrl.acc_bus;
  assign load_PC  = ctrl.load_pc;
  assign INC_PC   = ctrl.inc_pc;
  assign load_IR  = ctrl.load_ir;
  assign load_MAR = ctrl.load_mar;
  assign load_ACC = ctrl.load_acc;
  assign ALU_ACC  = ctrl.alu_acc;
  assign ALU_add  = ctrl.alu_add;
  assign ALU_sub  = ctrl.alu_sub;
  assign CS       = ctrl.cs;
  assign R_NW     = ctrl.r_nw;

`ifdef SEQ_HALT_EN
  assign halted = (state_q == HALT);
`else
  assign halted = 1'b0;
`endif

  a_op_fits: assert property (
    @(posedge clock) OP_W <= WORD_W);
  a_one_bus: assert property (
    @(posedge clock) disable iff (!n_reset)
    $onehot0({PC_bus, IR_bus, ACC_bus}));
  a_alu_op: assert property (
    @(posedge clock) disable iff (!n_reset)
    !(ALU_add && ALU_sub));
  a_alu_ld: assert property (
    @(posedge clock) disable iff (!n_reset)
    !ALU_ACC || load_ACC);
  a_inc_ld: assert property (
    @(posedge clock) disable iff (!n_reset)
    !INC_PC || load_PC);
  a_rnw_cs: assert property (
    @(posedge clock) disable iff (!n_reset)
    CS || !R_NW);
  // An undriven opcode decodes as a NOP, but it is still a bug upstream.
  a_op_known: assert property (
    @(posedge clock) disable iff (!n_reset)
    !(state_q == DECODE && $isunknown(op)));

endmodule

// File: tb/tb_sequencer.sv
// Randomized bench for sequencer against an instruction-level strobe model.
// Define SEQ_HALT_EN here too when building the DUT with the halt feature.
module tb_sequencer;

  logic       clock;
  logic       n_reset;
  logic [2:0] op;
  logic       z_flag;
  logic PC_bus, IR_bus, ACC_bus, load_PC, INC_PC, load_IR, load_MAR;
  logic load_ACC, ALU_ACC, ALU_add, ALU_sub, CS, R_NW, halted;

  sequencer dut (
    .clock   (clock),
    .n_reset (n_reset),
    .op      (op),
    .z_flag  (z_flag),
    .PC_bus  (PC_bus),
    .IR_bus  (IR_bus),
    .ACC_bus (ACC_bus),
    .load_PC (load_PC),
    .INC_PC  (INC_PC),
    .load_IR (load_IR),
    .load_MAR(load_MAR),
    .load_ACC(load_ACC),
    .ALU_ACC (ALU_ACC),
    .ALU_add (ALU_add),
    .ALU_sub (ALU_sub),
    .CS      (CS),
    .R_NW    (R_NW),
    .halted  (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [13:0] PCB  = 14'b1 << 13;
  localparam logic [13:0] IRB  = 14'b1 << 12;
  localparam logic [13:0] ACCB = 14'b1 << 11;
  localparam logic [13:0] LPC  = 14'b1 << 10;
  localparam logic [13:0] INC  = 14'b1 << 9;
  localparam logic [13:0] LIR  = 14'b1 << 8;
  localparam logic [13:0] LMAR = 14'b1 << 7;
  localparam logic [13:0] LACC = 14'b1 << 6;
  localparam logic [13:0] AACC = 14'b1 << 5;
  localparam logic [13:0] AADD = 14'b1 << 4;
  localparam logic [13:0] ASUB = 14'b1 << 3;
  localparam logic [13:0] CSB  = 14'b1 << 2;
  localparam logic [13:0] RNW  = 14'b1 << 1;
  localparam logic [13:0] HLT  = 14'b1;

  localparam logic [2:0] I_LOAD  = 3'b000;
  localparam logic [2:0] I_STORE = 3'b001;
  localparam logic [2:0] I_ADD   = 3'b010;
  localparam logic [2:0] I_SUB   = 3'b011;
  localparam logic [2:0] I_BNE   = 3'b100;
  localparam logic [2:0] I_BEQ   = 3'b101;
  localparam logic [2:0] I_JMP   = 3'b110;
  localparam logic [2:0] I_HALT  = 3'b111;

  logic [13:0] obs;
  assign obs = {PC_bus, IR_bus, ACC_bus, load_PC, INC_PC,
                load_IR, load_MAR, load_ACC, ALU_ACC, ALU_add,
                ALU_sub, CS, R_NW, halted};

  int checks = 0;
  int errors = 0;
  logic [13:0] exp_q[$];

  task automatic check(input string tag, input logic [13:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Per-instruction strobe list: two fetch cycles, decode, optional execute.
  task automatic build(input logic [2:0] o, input logic z);
    exp_q.delete();
    exp_q.push_back(PCB | LMAR | LPC | INC);
    exp_q.push_back(CSB | RNW | LIR);
    case (o)
      I_LOAD: begin
        exp_q.push_back(IRB | LMAR);
        exp_q.push_back(CSB | RNW | LACC);
      end
      I_STORE: begin
        exp_q.push_back(IRB | LMAR);
        exp_q.push_back(ACCB | CSB);
      end
      I_ADD: begin
        exp_q.push_back(IRB | LMAR);
        exp_q.push_back(CSB | RNW | LACC | AACC | AADD);
      end
      I_SUB: begin
        exp_q.push_back(IRB | LMAR);
        exp_q.push_back(CSB | RNW | LACC | AACC | ASUB);
      end
      I_BNE:   exp_q.push_back(IRB | (z ? 14'b0 : LPC));
      I_BEQ:   exp_q.push_back(IRB | (z ? LPC : 14'b0));
      I_JMP:   exp_q.push_back(IRB | LPC);
      default: exp_q.push_back(IRB);
    endcase
  endtask

  // Entered at the edge into FETCH_A; ends at the edge after the last
  // cycle unless stopped early after n cycles.
  task automatic run_instr(input string tag, input logic [2:0] o,
                           input logic z, input int n);
    int lim;
    build(o, z);
    lim = (n > 0) ? n : exp_q.size();
    for (int i = 0; i < lim; i++) begin
      if (i > 0) @(posedge clock);
      #1;
      op     = (i < 2) ? 3'($urandom) : o;
      z_flag = (i == 2) ? z : 1'($urandom);
      #1;
      check($sformatf("%s op=%0d z=%0d cyc%0d", tag, o, z, i), exp_q[i]);
    end
    if (n <= 0) @(posedge clock);
  endtask

  initial begin
    logic [2:0] ro;
    n_reset = 1'b0;
    op      = 3'b000;
    z_flag  = 1'b0;
    #3;
    check("reset_async", 14'b0);
    repeat (2) @(posedge clock);
    #1;
    check("reset_held", 14'b0);
    #2 n_reset = 1'b1;
    #1;
    check("boot", 14'b0);
    @(posedge clock);

    run_instr("load", I_LOAD, 1'b0, 0);
    run_instr("store", I_STORE, 1'b1, 0);
    run_instr("add", I_ADD, 1'b0, 0);
    run_instr("sub", I_SUB, 1'b1, 0);
    run_instr("bne_nz", I_BNE, 1'b0, 0);
    run_instr("bne_z", I_BNE, 1'b1, 0);
    run_instr("beq_nz", I_BEQ, 1'b0, 0);
    run_instr("beq_z", I_BEQ, 1'b1, 0);
    run_instr("jmp", I_JMP, 1'b0, 0);

    for (int k = 0; k < 60; k++) begin
`ifdef SEQ_HALT_EN
      ro = 3'($urandom_range(0, 6));
`else
      ro = 3'($urandom_range(0, 7));
`endif
      run_instr("rand", ro, 1'($urandom), 0);
    end

    run_instr("pre_rst", I_ADD, 1'b0, 4);
    #2 n_reset = 1'b0;
    #1;
    check("rst_mid_exec", 14'b0);
    @(posedge clock);
    #1;
    check("rst_mid_held", 14'b0);
    #2 n_reset = 1'b1;
    #1;
    check("rst_boot", 14'b0);
    @(posedge clock);
    run_instr("post_rst", I_LOAD, 1'b0, 0);

`ifdef SEQ_HALT_EN
    run_instr("halt", I_HALT, 1'b0, 0);
    for (int c = 0; c < 20; c++) begin
      #1;
      op     = 3'($urandom);
      z_flag = 1'($urandom);
      #1;
      check($sformatf("halted cyc%0d", c), HLT);
      @(posedge clock);
    end
    #2 n_reset = 1'b0;
    #1;
    check("halt_rst", 14'b0);
    #1 n_reset = 1'b1;
    #1;
    check("halt_boot", 14'b0);
    @(posedge clock);
    run_instr("after_halt", I_JMP, 1'b0, 0);
`else
    run_instr("nop", I_HALT, 1'b1, 0);
    run_instr("after_nop", I_SUB, 1'b0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
